// File: rtl/hazard_ctrl_pkg.sv
// hazard_ctrl_pkg: opcode constant and FSM state type shared by hazard_ctrl and its bench.
package hazard_ctrl_pkg;
  localparam logic [6:0] OPCODE_LOAD = 7'b0000011;
  typedef enum logic [1:0] {RUN, I_WAIT, D_WAIT, BOTH_WAIT} state_t;
endpackage

// File: rtl/stall_perf_counters.sv
// stall_perf_counters: free-running wrap-around event counters for pipeline stalls and flushes.
module stall_perf_counters (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_cache_stall,
  input  logic        i_load_use_stall,
  input  logic        i_pipeline_flush,
  output logic [31:0] o_cache_stall_cycles,
  output logic [31:0] o_load_use_cycles,
  output logic [31:0] o_flush_count
);
  logic [31:0] r_cache, r_load, r_flush;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cache <= 32'd0;
      r_load  <= 32'd0;
      r_flush <= 32'd0;
    end else begin
      r_cache <= r_cache + {31'd0, i_cache_stall};
      r_load  <= r_load + {31'd0, i_load_use_stall};
      r_flush <= r_flush + {31'd0, i_pipeline_flush};
    end
  end
  assign o_cache_stall_cycles = r_cache;
  assign o_load_use_cycles    = r_load;
  assign o_flush_count        = r_flush;
endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: cache-miss freeze FSM, load-use bubble, branch flush and sticky wait timeout.
// Define STALL_PERF_EN to add 32-bit perf counter outputs.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] id_rs1_addr,
  input  logic [4:0] id_rs2_addr,
  input  logic       id_rs1_valid,
  input  logic       id_rs2_valid,
  input  logic [4:0] ex_rd_addr,
  input  logic       ex_rd_valid,
  input  logic [6:0] ex_opcode,
  input  logic       ex_branch_taken,
  input  logic       icache_miss,
  input  logic       dcache_miss,
  input  logic       icache_ready,
  input  logic       dcache_ready,
  output logic       cache_stall,
  output logic       load_use_stall,
  output logic       pipeline_flush,
  output logic       pc_write_en,
  output logic       if_id_write_en,
  output logic       stall_timeout
`ifdef STALL_PERF_EN
  ,
  output logic [31:0] perf_cache_stall_cycles,
  output logic [31:0] perf_load_use_cycles,
  output logic [31:0] perf_flush_count
`endif
);
  state_t      r_state, w_next;
  logic [15:0] r_wait_cnt;
  logic        r_timeout;
  logic        w_rs_hit;
  always_comb begin
    w_next = r_state;
    case (r_state)
      RUN:     w_next = (icache_miss && dcache_miss) ? BOTH_WAIT : dcache_miss ? D_WAIT : icache_miss ? I_WAIT : RUN;
      I_WAIT:  w_next = icache_ready ? RUN : dcache_miss ? BOTH_WAIT : I_WAIT;
      D_WAIT:  w_next = dcache_ready ? RUN : icache_miss ? BOTH_WAIT : D_WAIT;
      default: w_next = (icache_ready && dcache_ready) ? RUN : icache_ready ? D_WAIT : dcache_ready ? I_WAIT : BOTH_WAIT;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= RUN;
      r_wait_cnt <= 16'd0;
      r_timeout  <= 1'b0;
    end else begin
      r_state    <= w_next;
      r_wait_cnt <= (r_state == RUN) ? 16'd0 : (r_wait_cnt == 16'(TIMEOUT_CYCLES)) ? r_wait_cnt : r_wait_cnt + 16'd1;
      r_timeout  <= r_timeout || (r_wait_cnt == 16'(TIMEOUT_CYCLES));
    end
  end
  // Freeze whenever the FSM stays in or enters a wait; the completing cycle leads back to RUN.
  assign w_rs_hit       = (id_rs1_valid && id_rs1_addr == ex_rd_addr) || (id_rs2_valid && id_rs2_addr == ex_rd_addr);
  assign cache_stall    = !rst && (w_next != RUN);
  assign load_use_stall = !rst && ex_opcode == OPCODE_LOAD && ex_rd_valid && ex_rd_addr != 5'd0 && w_rs_hit && !ex_branch_taken && !cache_stall;
  assign pipeline_flush = !rst && ex_branch_taken && !cache_stall;
  assign pc_write_en    = !cache_stall && !load_use_stall;
  assign if_id_write_en = !cache_stall && !load_use_stall;
  assign stall_timeout  = r_timeout;
`ifdef STALL_PERF_EN
  stall_perf_counters u_perf (
    .clk                  (clk),
    .rst                  (rst),
    .i_cache_stall        (cache_stall),
    .i_load_use_stall     (load_use_stall),
    .i_pipeline_flush     (pipeline_flush),
    .o_cache_stall_cycles (perf_cache_stall_cycles),
    .o_load_use_cycles    (perf_load_use_cycles),
    .o_flush_count        (perf_flush_count)
  );
`endif
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed-vector bench for hazard_ctrl built with TIMEOUT_CYCLES=8.
module tb_hazard_ctrl;
  import hazard_ctrl_pkg::*;
  logic clk = 1'b0, rst;
  logic [4:0] rs1, rs2, rd;
  logic rs1_v, rs2_v, rd_v, br, im, dm, ir, dr;
  logic [6:0] op;
  logic cs, lu, fl, pcwe, ifwe, tmo;
`ifdef STALL_PERF_EN
  logic [31:0] p_cs, p_lu, p_fl;
`endif
  int vectors = 0, miscompares = 0;
  hazard_ctrl #(.TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .rst(rst),
    .id_rs1_addr(rs1), .id_rs2_addr(rs2), .id_rs1_valid(rs1_v), .id_rs2_valid(rs2_v),
    .ex_rd_addr(rd), .ex_rd_valid(rd_v), .ex_opcode(op), .ex_branch_taken(br),
    .icache_miss(im), .dcache_miss(dm), .icache_ready(ir), .dcache_ready(dr),
    .cache_stall(cs), .load_use_stall(lu), .pipeline_flush(fl),
    .pc_write_en(pcwe), .if_id_write_en(ifwe), .stall_timeout(tmo)
`ifdef STALL_PERF_EN
    , .perf_cache_stall_cycles(p_cs), .perf_load_use_cycles(p_lu), .perf_flush_count(p_fl)
`endif
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    vectors++;
    assert (obs === want) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
    end
  endtask
  task automatic outs(input string tag, input int c, input int l, input int f, input int we);
    chk({tag, ".cache_stall"}, 32'(cs), c);
    chk({tag, ".load_use"}, 32'(lu), l);
    chk({tag, ".flush"}, 32'(fl), f);
    chk({tag, ".pc_we"}, 32'(pcwe), we);
    chk({tag, ".if_id_we"}, 32'(ifwe), we);
  endtask
  task automatic st(input string tag, input state_t s);
    chk({tag, ".state"}, 32'(dut.r_state), 32'(s));
  endtask
  task automatic idle;
    {rs1, rs2, rd} = '0;
    {rs1_v, rs2_v, rd_v, br, im, dm, ir, dr} = '0;
    op = 7'd0;
  endtask
  task automatic nxt;
    @(posedge clk);
    #1;
  endtask
  task automatic load(input logic [4:0] d, input logic [4:0] a1, input logic v1, input logic [4:0] a2, input logic v2);
    op = OPCODE_LOAD; rd_v = 1'b1; rd = d;
    rs1 = a1; rs1_v = v1; rs2 = a2; rs2_v = v2;
  endtask
  initial begin
    idle();
    rst = 1'b1; im = 1'b1; br = 1'b1; load(5'd5, 5'd5, 1'b1, 5'd0, 1'b0);
    #4 outs("reset_gate", 0, 0, 0, 1);
    nxt();
    st("reset", RUN);
    chk("reset.timeout", 32'(tmo), 0);
    rst = 1'b0; idle();
    #4 outs("idle", 0, 0, 0, 1);
    // icache miss filled five cycles later; a stray dcache_ready is ignored
    nxt(); im = 1'b1;
    #4 outs("imiss.c0", 1, 0, 0, 0);
    for (int i = 1; i <= 4; i++) begin
      nxt(); dr = (i == 2);
      #4 outs("imiss.wait", 1, 0, 0, 0);
      st("imiss.wait", I_WAIT);
    end
    nxt(); dr = 1'b0; ir = 1'b1; im = 1'b0;
    #4 outs("imiss.ready", 0, 0, 0, 1);
    st("imiss.ready", I_WAIT);
    nxt(); idle();
    #4 st("imiss.done", RUN);
    chk("imiss.timeout", 32'(tmo), 0);
    // load-use hazards
    load(5'd5, 5'd3, 1'b1, 5'd5, 1'b1);
    #4 outs("lu.rs2", 0, 1, 0, 0);
    nxt(); idle();
    #4 outs("lu.bubble", 0, 0, 0, 1);
    nxt(); load(5'd0, 5'd0, 1'b1, 5'd0, 1'b1);
    #4 outs("lu.x0", 0, 0, 0, 1);
    nxt(); load(5'd5, 5'd3, 1'b1, 5'd5, 1'b0);
    #4 outs("lu.rs2_invalid", 0, 0, 0, 1);
    nxt(); load(5'd7, 5'd7, 1'b1, 5'd1, 1'b1);
    #4 outs("lu.rs1", 0, 1, 0, 0);
    nxt(); op = 7'b0110011;
    #4 outs("lu.not_load", 0, 0, 0, 1);
    nxt(); load(5'd5, 5'd3, 1'b1, 5'd5, 1'b1); br = 1'b1;
    #4 outs("lu.branch", 0, 0, 1, 1);
    // load hazard hidden by a dcache stall, exposed in the fill cycle
    nxt(); br = 1'b0; dm = 1'b1;
    #4 outs("lu.dstall", 1, 0, 0, 0);
    nxt(); dm = 1'b0; dr = 1'b1;
    #4 outs("lu.dready", 0, 1, 0, 0);
    nxt(); idle();
    #4 st("lu.done", RUN);
    // dcache miss, icache joins, dcache fills, icache fills
    dm = 1'b1;
    #4 outs("dual.c0", 1, 0, 0, 0);
    nxt();
    #4 outs("dual.c1", 1, 0, 0, 0);
    st("dual.c1", D_WAIT);
    nxt(); im = 1'b1;
    #4 outs("dual.c2", 1, 0, 0, 0);
    nxt(); dm = 1'b0; dr = 1'b1;
    #4 outs("dual.c3", 1, 0, 0, 0);
    st("dual.c3", BOTH_WAIT);
    nxt(); dr = 1'b0;
    #4 outs("dual.c4", 1, 0, 0, 0);
    st("dual.c4", I_WAIT);
    nxt(); im = 1'b0; ir = 1'b1;
    #4 outs("dual.c5", 0, 0, 0, 1);
    nxt(); idle();
    #4 st("dual.done", RUN);
    // both fills in one cycle
    im = 1'b1; dm = 1'b1;
    nxt(); im = 1'b0; dm = 1'b0; ir = 1'b1; dr = 1'b1;
    #4 st("both.wait", BOTH_WAIT);
    outs("both.ready", 0, 0, 0, 1);
    nxt(); idle();
    #4 st("both.done", RUN);
    // branch held across a 3-cycle dcache stall
    dm = 1'b1; br = 1'b1;
    #4 outs("br.c0", 1, 0, 0, 0);
    nxt();
    #4 outs("br.c1", 1, 0, 0, 0);
    nxt();
    #4 outs("br.c2", 1, 0, 0, 0);
    nxt(); dm = 1'b0; dr = 1'b1;
    #4 outs("br.ready", 0, 0, 1, 1);
    nxt(); idle();
    #4 st("br.done", RUN);
    // unfilled miss: timeout, saturation, then reset mid-wait
    im = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      nxt();
      #4 chk("tmo.low", 32'(tmo), 0);
    end
    nxt();
    #4 chk("tmo.set", 32'(tmo), 1);
    chk("tmo.cnt", 32'(dut.r_wait_cnt), 8);
    nxt();
    #4 chk("tmo.hold", 32'(tmo), 1);
    chk("tmo.sat", 32'(dut.r_wait_cnt), 8);
    rst = 1'b1;
    #4 outs("tmo.rst", 0, 0, 0, 1);
    nxt(); rst = 1'b0;
    #4 chk("tmo.cleared", 32'(tmo), 0);
    st("tmo.rst", RUN);
    outs("tmo.reaccept", 1, 0, 0, 0);
    nxt();
    #4 st("tmo.rewait", I_WAIT);
    im = 1'b0; ir = 1'b1;
    nxt(); idle();
    #4 st("tmo.done", RUN);
    chk("tmo.final", 32'(tmo), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 1024, giving consecutive cache-wait cycles before a timeout is flagged.
REQ-002 SHALL have these ports (name, direction, width, meaning):
- clk, in, 1: the single clock.
- rst, in, 1: reset; synchronous and active-high.
- id_rs1_addr / id_rs2_addr, in, 5: decode-stage source registers.
- id_rs1_valid / id_rs2_valid, in, 1: the decode-stage sources are used.
- ex_rd_addr, in, 5: execute-stage destination register.
- ex_rd_valid, in, 1: the execute-stage instruction writes ex_rd_addr.
- ex_opcode, in, 7: execute-stage opcode.
- ex_branch_taken, in, 1: a branch or jump resolved taken in execute.
- icache_miss / dcache_miss, in, 1: miss request (level).
- icache_ready / dcache_ready, in, 1: miss fill complete (1-cycle pulse).
- cache_stall, out, 1: global freeze of all pipeline registers.
- load_use_stall, out, 1: insert a bubble into ID/EX.
- pipeline_flush, out, 1: squash IF/ID and ID/EX.
- pc_write_en, out, 1: PC update enable.
- if_id_write_en, out, 1: IF/ID update enable.
- stall_timeout, out, 1: sticky timeout flag.

Function
REQ-003 SHALL implement FSM states RUN, I_WAIT, D_WAIT, BOTH_WAIT; the state SHALL be RUN after reset.
REQ-004 In RUN, the next state SHALL be:
- BOTH_WAIT if icache_miss and dcache_miss are both asserted.
- D_WAIT if only dcache_miss is asserted.
- I_WAIT if only icache_miss is asserted.
- RUN otherwise.
REQ-005 I_WAIT SHALL go to RUN on icache_ready, and to BOTH_WAIT on dcache_miss without icache_ready; D_WAIT SHALL behave symmetrically.
REQ-006 BOTH_WAIT SHALL go to:
- D_WAIT on icache_ready alone.
- I_WAIT on dcache_ready alone.
- RUN when both ready signals arrive in the same cycle.
REQ-007 cache_stall SHALL be combinational:
- Asserted in RUN in the same cycle any miss is asserted.
- Asserted in every wait cycle, except deasserted in the cycle that completes all outstanding misses.
REQ-008 load_use_stall SHALL equal (ex_opcode==OPCODE_LOAD) AND ex_rd_valid AND ex_rd_addr!=0 AND (a valid rs1 matches OR a valid rs2 matches) AND NOT ex_branch_taken AND NOT cache_stall.
REQ-009 pipeline_flush SHALL equal ex_branch_taken AND NOT cache_stall; flush SHALL take priority over load_use_stall.
REQ-010 A branch resolving during a cache stall SHALL flush in the first unstalled cycle, since execute is frozen and ex_branch_taken persists; no pending register is needed.
REQ-011 pc_write_en and if_id_write_en SHALL each equal NOT cache_stall AND NOT load_use_stall; during a flush both SHALL be 1.
REQ-012 A 16-bit wait counter SHALL clear in RUN and increment in every non-RUN cycle, saturating at TIMEOUT_CYCLES.
REQ-013 stall_timeout SHALL set one cycle after the wait counter reaches TIMEOUT_CYCLES and SHALL hold until rst.
REQ-014 A ready pulse for a cache not being waited on SHALL be ignored.

Reset
REQ-015 While rst=1 at a clk edge, the module SHALL load state=RUN, wait counter=0, stall_timeout=0, and all perf counters=0.
REQ-016 During reset, cache_stall, load_use_stall and pipeline_flush SHALL be 0, and pc_write_en and if_id_write_en SHALL be 1.
REQ-017 Reset asserted mid-wait SHALL abandon the wait; a miss still held after reset SHALL be re-accepted from RUN.

Configuration
REQ-018 With STALL_PERF_EN defined, the module SHALL add outputs perf_cache_stall_cycles, perf_load_use_cycles and perf_flush_count (32 bits each).
REQ-019 Each perf counter SHALL increment once per cycle in which its signal is asserted, and SHALL wrap at 2^32.
REQ-020 Without STALL_PERF_EN, those ports and registers SHALL be absent and all other behaviour SHALL be identical.

Structure
REQ-021 A shared package SHALL hold OPCODE_LOAD (7'b0000011) and the 2-bit FSM state typedef.
REQ-022 The perf counters SHALL live in sub-module stall_perf_counters, instantiated only under STALL_PERF_EN.

Verification
REQ-023 The bench SHALL cover these directed scenarios (stimulus -> required response):
- icache_miss in RUN, icache_ready 5 cycles later -> cache_stall=1 for exactly 5 cycles, 0 in the ready cycle, state I_WAIT->RUN.
- Load with ex_rd_addr=5 and id_rs2_addr=5 valid -> load_use_stall=1, pc_write_en=0, one cycle; repeat with ex_rd_addr=0 -> no stall.
- Load hazard plus ex_branch_taken in the same cycle -> pipeline_flush=1, load_use_stall=0, pc_write_en=1.
- dcache_miss, then icache_miss 2 cycles later, dcache_ready, then icache_ready -> states D_WAIT->BOTH_WAIT->I_WAIT->RUN; cache_stall continuous.
- ex_branch_taken held during a 3-cycle dcache stall -> pipeline_flush=0 during the stall, then 1 in the ready cycle.
- TIMEOUT_CYCLES=8, miss never filled -> stall_timeout rises after 8 wait cycles, stays 1, and is cleared only by rst.
